// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential shifter: operation encodings and FSM states.
package seq_shifter_pkg;

    typedef enum logic [2:0] {
        MODE_LSL = 3'd0,
        MODE_LSR = 3'd1,
        MODE_ASR = 3'd2,
        MODE_ROL = 3'd3,
        MODE_ROR = 3'd4,
        MODE_RCL = 3'd5,
        MODE_RCR = 3'd6,
        MODE_NOP = 3'd7
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shifter_state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One single-bit shift/rotate step; purely combinational.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  shift_mode_t     mode,
    input  logic [SIZE-1:0] d,
    input  logic            c,
    output logic [SIZE-1:0] d_next,
    output logic            c_next
);

    always_comb begin
        d_next = d;
        c_next = c;
        case (mode)
            MODE_LSL: begin d_next = {d[SIZE-2:0], 1'b0};      c_next = d[SIZE-1]; end
            MODE_LSR: begin d_next = {1'b0, d[SIZE-1:1]};      c_next = d[0];      end
            MODE_ASR: begin d_next = {d[SIZE-1], d[SIZE-1:1]}; c_next = d[0];      end
            MODE_ROL: begin d_next = {d[SIZE-2:0], d[SIZE-1]}; c_next = d[SIZE-1]; end
            MODE_ROR: begin d_next = {d[0], d[SIZE-1:1]};      c_next = d[0];      end
            MODE_RCL: begin d_next = {d[SIZE-2:0], c};         c_next = d[SIZE-1]; end
            MODE_RCR: begin d_next = {c, d[SIZE-1:1]};         c_next = d[0];      end
            default:  begin d_next = d;                        c_next = c;         end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one single-bit step per cycle for 'amount' cycles,
// then a one-cycle done pulse. Result and carry hold until the next accept.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int AMT_WIDTH = $clog2(SIZE+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           mode,
    input  logic [AMT_WIDTH-1:0] amount,
    input  logic [SIZE-1:0]      data,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [SIZE-1:0]      data_out,
    output logic                 carry_out,
    output logic                 zero_out
);

    shifter_state_t       state, state_nxt;
    shift_mode_t          mode_q;
    logic [AMT_WIDTH-1:0] cnt;
    logic [SIZE-1:0]      d_next;
    logic                 c_next;
    logic                 accept;

    // DONE also accepts, so back-to-back operations need no idle cycle.
    assign accept = start && (state != ST_SHIFT);

    shift_step #(.SIZE(SIZE)) u_step (
        .mode   (mode_q),
        .d      (data_out),
        .c      (carry_out),
        .d_next (d_next),
        .c_next (c_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_nxt = (amount == '0) ? ST_DONE : ST_SHIFT;
                else        state_nxt = ST_IDLE;
            end
            ST_SHIFT: if (cnt == AMT_WIDTH'(1)) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            carry_out <= 1'b0;
            cnt       <= '0;
            mode_q    <= MODE_NOP;
        end else if (accept) begin
            data_out  <= data;
            carry_out <= carry_in;
            cnt       <= amount;
            mode_q    <= shift_mode_t'(mode);
        end else if (state == ST_SHIFT) begin
            data_out  <= d_next;
            carry_out <= c_next;
            cnt       <= cnt - AMT_WIDTH'(1);
        end
    end

    assign zero_out = ~|data_out;

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized + directed bench for seq_shifter against a closed-form shift model.
module tb_seq_shifter;

    localparam int SIZE = 8;
    localparam int AW   = $clog2(SIZE+1);

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      mode;
    logic [AW-1:0]   amount;
    logic [SIZE-1:0] data;
    logic            carry_in;
    logic            busy, done, carry_out, zero_out;
    logic [SIZE-1:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [SIZE-1:0] last_d;
    logic            last_c;

    seq_shifter #(.SIZE(SIZE), .AMT_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .data      (data),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .carry_out (carry_out),
        .zero_out  (zero_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Result of n steps as {carry, data}, from whole-word shifts/rotations.
    function automatic logic [SIZE:0] model(input int m, input int n,
                                            input logic [SIZE-1:0] d, input logic c);
        logic [63:0]     w;
        longint          s;
        logic [SIZE-1:0] r;
        logic [SIZE:0]   v;
        int              k;
        if (n == 0 || m == 7) return {c, d};
        v = {c, d};
        case (m)
            0: begin w = 64'(d) << n; return {w[SIZE], w[SIZE-1:0]}; end
            1: begin w = ((64'(d) << 1) | 64'(c)) >> n; return {w[0], w[SIZE:1]}; end
            2: begin
                s = (longint'($signed(d)) <<< 1) | longint'(c);
                s = s >>> n;
                return {s[0], s[SIZE:1]};
            end
            3: begin k = n % SIZE; r = (d << k) | (d >> (SIZE-k)); return {r[0], r}; end
            4: begin k = n % SIZE; r = (d >> k) | (d << (SIZE-k)); return {r[SIZE-1], r}; end
            5: begin k = n % (SIZE+1); v = (v << k) | (v >> (SIZE+1-k)); return v; end
            6: begin k = n % (SIZE+1); v = (v >> k) | (v << (SIZE+1-k)); return v; end
            default: return {c, d};
        endcase
    endfunction

    // Called just after a rising edge; returns at the sample where done is seen.
    task automatic do_op(input int m, input int n, input logic [SIZE-1:0] d,
                         input logic c, input string tag);
        logic [SIZE:0] exp;
        int cyc;
        exp = model(m, n, d, c);
        start = 1'b1; mode = m[2:0]; amount = AW'(n); data = d; carry_in = c;
        for (cyc = 1; cyc <= n + 5; cyc++) begin
            @(posedge clk); #1;
            if (done) break;
            chk({tag, " busy"}, 64'(busy), 64'(1));
            // Garbage on every input while busy must not disturb the operation.
            start = 1'($urandom); mode = 3'($urandom); amount = AW'($urandom);
            data = SIZE'($urandom); carry_in = 1'($urandom);
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(cyc), 64'(n + 1));
        chk({tag, " busy@done"}, 64'(busy), 64'(0));
        chk({tag, " data"}, 64'(data_out), 64'(exp[SIZE-1:0]));
        chk({tag, " carry"}, 64'(carry_out), 64'(exp[SIZE]));
        chk({tag, " zero"}, 64'(zero_out), 64'(exp[SIZE-1:0] == '0));
        last_d = exp[SIZE-1:0];
        last_c = exp[SIZE];
    endtask

    task automatic idle(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            chk({tag, " idle done"}, 64'(done), 64'(0));
            chk({tag, " idle busy"}, 64'(busy), 64'(0));
            chk({tag, " hold data"}, 64'(data_out), 64'(last_d));
            chk({tag, " hold carry"}, 64'(carry_out), 64'(last_c));
        end
    endtask

    initial begin
        logic [SIZE:0] mid;
        reset = 1'b1; start = 1'b0; mode = '0; amount = '0; data = '0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst data", 64'(data_out), 64'(0));
        chk("rst carry", 64'(carry_out), 64'(0));
        chk("rst zero", 64'(zero_out), 64'(1));
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(0, 1, 8'h81, 1'b0, "lsl81");
        idle(1, "lsl81");
        do_op(2, 3, 8'h90, 1'b0, "asr90");
        idle(1, "asr90");
        do_op(6, 9, 8'h01, 1'b0, "rcr9");
        idle(1, "rcr9");
        do_op(1, 8, 8'hFF, 1'b0, "lsr8");
        idle(1, "lsr8");
        do_op(3, 0, 8'h5A, 1'b1, "rol0");
        idle(1, "rol0");

        // Back-to-back: second start presented in the DONE cycle.
        do_op(0, 1, 8'h81, 1'b0, "b2b_a");
        do_op(4, 1, 8'h01, 1'b0, "b2b_b");
        chk("b2b data", 64'(data_out), 64'h80);
        chk("b2b carry", 64'(carry_out), 64'(1));
        idle(2, "b2b");

        // Ignored second start, then reset mid-operation.
        start = 1'b1; mode = 3'd0; amount = AW'(5); data = 8'h3C; carry_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; data = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        mid = model(0, 2, 8'h3C, 1'b0);
        chk("abort mid data", 64'(data_out), 64'(mid[SIZE-1:0]));
        chk("abort mid busy", 64'(busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort data", 64'(data_out), 64'(0));
        chk("abort carry", 64'(carry_out), 64'(0));
        chk("abort zero", 64'(zero_out), 64'(1));
        last_d = '0; last_c = 1'b0;
        idle(6, "abort");

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; mode = 3'd3; amount = AW'(2); data = 8'hA5; carry_in = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("rst>start busy", 64'(busy), 64'(0));
        chk("rst>start done", 64'(done), 64'(0));
        chk("rst>start data", 64'(data_out), 64'(0));
        idle(2, "rst>start");

        for (int i = 0; i < 60; i++) begin
            int g;
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                  SIZE'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
            g = int'($urandom_range(0, 2));
            if (g > 0) idle(g, $sformatf("rnd%0d", i));
        end
        idle(1, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
